// File: rtl/btb_assoc_if.sv
// Lookup and resolve bundle for the set-associative BTB.
// The fetch/branch-stack side drives it as master; the BTB is the slave.
interface btb_assoc_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_BITS = 32
);
    logic [NUM_PORTS-1:0]                lookup_valid;
    logic [NUM_PORTS-1:0][ADDR_BITS-1:0] lookup_pc;
    logic [NUM_PORTS-1:0]                btb_hit;
    logic [NUM_PORTS-1:0][ADDR_BITS-1:0] target_pc;
    logic                                resolve_valid;
    logic [ADDR_BITS-1:0]                resolve_pc;
    logic [ADDR_BITS-1:0]                resolve_target;
    logic                                resolve_taken;

    modport master (
        output lookup_valid, lookup_pc, resolve_valid, resolve_pc, resolve_target, resolve_taken,
        input  btb_hit, target_pc
    );

    modport slave (
        input  lookup_valid, lookup_pc, resolve_valid, resolve_pc, resolve_target, resolve_taken,
        output btb_hit, target_pc
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: multi-port same-cycle lookup, one resolve per cycle, true LRU.
// Define BTB_BYPASS_EN to forward a same-cycle resolve onto matching lookups.
module btb_assoc #(
    parameter int NUM_PORTS = 2,
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 4,
    parameter int TAG_BITS  = 10,
    parameter int ADDR_BITS = 32
) (
    input  logic        clock,
    input  logic        reset,
    btb_assoc_if.slave  bus
);
    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int AGE_BITS = $clog2(NUM_WAYS);

    typedef logic [NUM_WAYS-1:0][AGE_BITS-1:0] ages_t;

    logic [NUM_WAYS-1:0]  valid_reg  [NUM_SETS];
    logic [TAG_BITS-1:0]  tag_reg    [NUM_SETS][NUM_WAYS];
    logic [ADDR_BITS-1:0] target_reg [NUM_SETS][NUM_WAYS];
    ages_t                age_reg    [NUM_SETS];
    ages_t                age_next   [NUM_SETS];

    logic [NUM_PORTS-1:0] raw_hit;
    logic [AGE_BITS-1:0]  hit_way [NUM_PORTS];
    logic [IDX_BITS-1:0]  lk_set  [NUM_PORTS];

    logic [IDX_BITS-1:0]  res_set;
    logic [TAG_BITS-1:0]  res_tag;
    logic                 res_hit;
    logic [AGE_BITS-1:0]  res_way;
    logic [AGE_BITS-1:0]  victim;
    logic [AGE_BITS-1:0]  wr_way;
    logic                 unused_bits;

    assign res_set     = bus.resolve_pc[2 +: IDX_BITS];
    assign res_tag     = bus.resolve_pc[2+IDX_BITS +: TAG_BITS];
    assign unused_bits = ^{bus.lookup_pc, bus.resolve_pc};

    // Ways younger than the touched one age by one; the touched way becomes MRU.
    function automatic ages_t touch(ages_t ages, logic [AGE_BITS-1:0] way);
        ages_t r;
        r = ages;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (ages[i] < ages[way]) begin
                r[i] = ages[i] + 1'b1;
            end
        end
        r[way] = '0;
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [IDX_BITS-1:0]  set_idx;
            logic [TAG_BITS-1:0]  tag;
            logic [NUM_WAYS-1:0]  match;
            logic [ADDR_BITS-1:0] way_target;
            logic [AGE_BITS-1:0]  way;
            logic                 hit;
            logic [ADDR_BITS-1:0] out_target;

            assign set_idx = bus.lookup_pc[gi][2 +: IDX_BITS];
            assign tag     = bus.lookup_pc[gi][2+IDX_BITS +: TAG_BITS];

            // Tags are unique within a set, so OR-ing the matching ways selects one.
            always_comb begin
                match      = '0;
                way_target = '0;
                way        = '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    match[w] = valid_reg[set_idx][w] && (tag_reg[set_idx][w] == tag);
                    if (match[w]) begin
                        way_target = way_target | target_reg[set_idx][w];
                        way        = way | AGE_BITS'(w);
                    end
                end
            end

            assign raw_hit[gi] = bus.lookup_valid[gi] && (|match);
            assign hit_way[gi] = way;
            assign lk_set[gi]  = set_idx;

            always_comb begin
                hit        = raw_hit[gi];
                out_target = way_target;
`ifdef BTB_BYPASS_EN
                if (bus.resolve_valid && bus.lookup_valid[gi] &&
                    (res_set == set_idx) && (res_tag == tag)) begin
                    hit        = bus.resolve_taken;
                    out_target = bus.resolve_target;
                end
`endif
                if (reset || !hit) begin
                    hit        = 1'b0;
                    out_target = '0;
                end
            end

            assign bus.btb_hit[gi]   = hit;
            assign bus.target_pc[gi] = out_target;
        end
    endgenerate

    always_comb begin
        res_hit = 1'b0;
        res_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_reg[res_set][w] && (tag_reg[res_set][w] == res_tag)) begin
                res_hit = 1'b1;
                res_way = res_way | AGE_BITS'(w);
            end
        end
    end

    // Lookup touches go first in port order; the resolve then picks its victim
    // from those post-touch ages and takes the final MRU slot.
    always_comb begin
        ages_t set_ages;
        logic  free_found;
        for (int s = 0; s < NUM_SETS; s++) begin
            age_next[s] = age_reg[s];
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (raw_hit[p]) begin
                age_next[lk_set[p]] = touch(age_next[lk_set[p]], hit_way[p]);
            end
        end
        set_ages   = age_next[res_set];
        free_found = 1'b0;
        victim     = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!free_found && !valid_reg[res_set][w]) begin
                free_found = 1'b1;
                victim     = AGE_BITS'(w);
            end
        end
        if (!free_found) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (set_ages[w] == AGE_BITS'(NUM_WAYS-1)) begin
                    victim = AGE_BITS'(w);
                end
            end
        end
        wr_way = res_hit ? res_way : victim;
        if (bus.resolve_valid && bus.resolve_taken) begin
            age_next[res_set] = touch(set_ages, wr_way);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_reg[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_reg[s][w] <= AGE_BITS'(w);
                end
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                age_reg[s] <= age_next[s];
            end
            if (bus.resolve_valid) begin
                if (bus.resolve_taken) begin
                    valid_reg[res_set][wr_way]  <= 1'b1;
                    tag_reg[res_set][wr_way]    <= res_tag;
                    target_reg[res_set][wr_way] <= bus.resolve_target;
                end else if (res_hit) begin
                    valid_reg[res_set][res_way] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed vector table, hand sequences for the
// same-cycle/reset corners, then random traffic against an MRU-list model.
module tb_btb_assoc;
    localparam int NP = 2;
    localparam int NS = 16;
    localparam int NW = 4;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    btb_assoc_if #(.NUM_PORTS(NP), .ADDR_BITS(32)) bus ();

    btb_assoc #(.NUM_PORTS(NP), .NUM_SETS(NS), .NUM_WAYS(NW), .TAG_BITS(10), .ADDR_BITS(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit [1:0]    lv;
        logic [31:0] pc0;
        logic [31:0] pc1;
        bit          rv;
        logic [31:0] rpc;
        logic [31:0] rtgt;
        bit          tk;
        bit [1:0]    hit;
        logic [31:0] t0;
        logic [31:0] t1;
    } vec_t;

    vec_t vecs[$];

    // Reference model: per-set list of ways ordered most- to least-recently used.
    bit          m_valid [NS][NW];
    logic [9:0]  m_tag   [NS][NW];
    logic [31:0] m_tgt   [NS][NW];
    int          m_lru   [NS][$];

    function automatic void add(bit [1:0] lv, logic [31:0] pc0, logic [31:0] pc1, bit rv,
                                logic [31:0] rpc, logic [31:0] rtgt, bit tk,
                                bit [1:0] hit, logic [31:0] t0, logic [31:0] t1);
        vec_t v;
        v.lv = lv; v.pc0 = pc0; v.pc1 = pc1; v.rv = rv; v.rpc = rpc; v.rtgt = rtgt; v.tk = tk;
        v.hit = hit; v.t0 = t0; v.t1 = t1;
        vecs.push_back(v);
    endfunction

    function automatic int set_of(logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) begin
            m_lru[s].delete();
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_lru[s].push_back(w);
            end
        end
    endfunction

    function automatic int model_find(logic [31:0] pc);
        int s = set_of(pc);
        for (int w = 0; w < NW; w++)
            if (m_valid[s][w] && m_tag[s][w] == pc[15:6]) return w;
        return -1;
    endfunction

    function automatic void model_touch(int s, int w);
        for (int i = 0; i < m_lru[s].size(); i++) begin
            if (m_lru[s][i] == w) begin
                m_lru[s].delete(i);
                break;
            end
        end
        m_lru[s].push_front(w);
    endfunction

    function automatic void model_step(bit [1:0] lv, logic [31:0] pc0, logic [31:0] pc1, bit rv,
                                       logic [31:0] rpc, logic [31:0] rtgt, bit tk);
        logic [31:0] pcs [NP];
        int s, w;
        pcs[0] = pc0; pcs[1] = pc1;
        for (int p = 0; p < NP; p++) begin
            if (lv[p]) begin
                w = model_find(pcs[p]);
                if (w >= 0) model_touch(set_of(pcs[p]), w);
            end
        end
        if (rv) begin
            s = set_of(rpc);
            w = model_find(rpc);
            if (tk) begin
                if (w < 0) begin
                    for (int i = NW - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
                    if (w < 0) w = m_lru[s][NW-1];
                    m_valid[s][w] = 1'b1;
                    m_tag[s][w]   = rpc[15:6];
                end
                m_tgt[s][w] = rtgt;
                model_touch(s, w);
            end else if (w >= 0) begin
                m_valid[s][w] = 1'b0;
            end
        end
    endfunction

    task automatic drive(bit rst, bit [1:0] lv, logic [31:0] pc0, logic [31:0] pc1, bit rv,
                         logic [31:0] rpc, logic [31:0] rtgt, bit tk);
        @(negedge clock);
        reset              = rst;
        bus.lookup_valid   = lv;
        bus.lookup_pc[0]   = pc0;
        bus.lookup_pc[1]   = pc1;
        bus.resolve_valid  = rv;
        bus.resolve_pc     = rpc;
        bus.resolve_target = rtgt;
        bus.resolve_taken  = tk;
        #2;
    endtask

    task automatic check_port(string name, int p, bit exp_hit, logic [31:0] exp_tgt);
        checks++;
        if (bus.btb_hit[p] !== exp_hit || bus.target_pc[p] !== exp_tgt) begin
            errors++;
            $display("FAIL %s port%0d: got hit=%0b target=%h, expected hit=%0b target=%h",
                     name, p, bus.btb_hit[p], bus.target_pc[p], exp_hit, exp_tgt);
        end
    endtask

    localparam logic [31:0] PA = 32'h0000_0048;
    localparam logic [31:0] PB = 32'h0000_0088;
    localparam logic [31:0] PC = 32'h0000_00C8;
    localparam logic [31:0] PD = 32'h0000_0108;
    localparam logic [31:0] PE = 32'h0000_0148;
    localparam logic [31:0] PF = 32'h0000_0188;

    initial begin
        bit [1:0]    lv;
        logic [31:0] pc0, pc1, rpc, rtgt;
        bit          rv, tk, rst;
        bit          e_hit [NP];
        logic [31:0] e_tgt [NP];
        logic [31:0] pcs [NP];
        int          w;

        reset = 1'b1;
        bus.lookup_valid = '0; bus.lookup_pc = '0;
        bus.resolve_valid = 1'b0; bus.resolve_pc = '0; bus.resolve_target = '0; bus.resolve_taken = 1'b0;

        //   lv     pc0        pc1           rv  rpc        rtgt          tk  hit    t0            t1
        add(2'b11, 32'h1000,  32'h1000,     0,  32'h0,     32'h0,        0,  2'b00, 32'h0,        32'h0);
        add(2'b00, 32'h0,     32'h0,        1,  32'h1000,  32'h2000,     1,  2'b00, 32'h0,        32'h0);
        add(2'b11, 32'h1000,  32'h1004,     0,  32'h0,     32'h0,        0,  2'b01, 32'h2000,     32'h0);
        add(2'b00, 32'h0,     32'h0,        1,  PA,        32'hA000,     1,  2'b00, 32'h0,        32'h0);
        add(2'b00, 32'h0,     32'h0,        1,  PB,        32'hB000,     1,  2'b00, 32'h0,        32'h0);
        add(2'b00, 32'h0,     32'h0,        1,  PC,        32'hC000,     1,  2'b00, 32'h0,        32'h0);
        add(2'b00, 32'h0,     32'h0,        1,  PD,        32'hD000,     1,  2'b00, 32'h0,        32'h0);
        add(2'b01, PA,        32'h0,        0,  32'h0,     32'h0,        0,  2'b01, 32'hA000,     32'h0);
        add(2'b00, 32'h0,     32'h0,        1,  PE,        32'hE000,     1,  2'b00, 32'h0,        32'h0);
        add(2'b11, PA,        PC,           0,  32'h0,     32'h0,        0,  2'b11, 32'hA000,     32'hC000);
        add(2'b11, PD,        PE,           0,  32'h0,     32'h0,        0,  2'b11, 32'hD000,     32'hE000);
        add(2'b01, PB,        32'h1000,     0,  32'h0,     32'h0,        0,  2'b00, 32'h0,        32'h0);
        add(2'b00, 32'h0,     32'h0,        1,  PA,        32'h0,        0,  2'b00, 32'h0,        32'h0);
        add(2'b11, PA,        PC,           0,  32'h0,     32'h0,        0,  2'b10, 32'h0,        32'hC000);
        add(2'b00, 32'h0,     32'h0,        1,  PF,        32'hF000,     1,  2'b00, 32'h0,        32'h0);
        add(2'b11, PF,        PC,           0,  32'h0,     32'h0,        0,  2'b11, 32'hF000,     32'hC000);
        add(2'b11, PD,        PE,           0,  32'h0,     32'h0,        0,  2'b11, 32'hD000,     32'hE000);

        drive(1, 2'b11, 32'h1000, 32'h1000, 0, 0, 0, 0);
        check_port("reset_out", 0, 1'b0, 32'h0);
        check_port("reset_out", 1, 1'b0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(0, vecs[i].lv, vecs[i].pc0, vecs[i].pc1, vecs[i].rv, vecs[i].rpc, vecs[i].rtgt, vecs[i].tk);
            $display("vec %0d: hit=%b t0=%h t1=%h", i, bus.btb_hit, bus.target_pc[0], bus.target_pc[1]);
            check_port($sformatf("vec%0d", i), 0, vecs[i].hit[0], vecs[i].t0);
            check_port($sformatf("vec%0d", i), 1, vecs[i].hit[1], vecs[i].t1);
        end

        // Same-cycle taken resolve against a lookup of the same PC.
        drive(0, 2'b01, 32'h1000, 32'h0, 1, 32'h1000, 32'h3000, 1);
        $display("same-cycle taken: hit=%b t0=%h", bus.btb_hit, bus.target_pc[0]);
`ifdef BTB_BYPASS_EN
        check_port("same_cycle_taken", 0, 1'b1, 32'h3000);
`else
        check_port("same_cycle_taken", 0, 1'b1, 32'h2000);
`endif
        drive(0, 2'b01, 32'h1000, 32'h0, 0, 0, 0, 0);
        $display("after taken: hit=%b t0=%h", bus.btb_hit, bus.target_pc[0]);
        check_port("after_taken", 0, 1'b1, 32'h3000);

        // Same-cycle not-taken resolve, duplicate PC on both ports.
        drive(0, 2'b11, 32'h1000, 32'h1000, 1, 32'h1000, 32'h0, 0);
        $display("same-cycle not-taken: hit=%b t0=%h t1=%h", bus.btb_hit, bus.target_pc[0], bus.target_pc[1]);
`ifdef BTB_BYPASS_EN
        check_port("same_cycle_nt", 0, 1'b0, 32'h0);
        check_port("same_cycle_nt", 1, 1'b0, 32'h0);
`else
        check_port("same_cycle_nt", 0, 1'b1, 32'h3000);
        check_port("same_cycle_nt", 1, 1'b1, 32'h3000);
`endif
        drive(0, 2'b01, 32'h1000, 32'h0, 0, 0, 0, 0);
        $display("after not-taken: hit=%b", bus.btb_hit);
        check_port("after_nt", 0, 1'b0, 32'h0);

        // Reset asserted with a resolve pending; F and C are valid going in.
        drive(1, 2'b11, PF, PC, 1, PA, 32'hAAAA, 1);
        $display("in reset: hit=%b", bus.btb_hit);
        check_port("reset_gate", 0, 1'b0, 32'h0);
        check_port("reset_gate", 1, 1'b0, 32'h0);
        drive(0, 2'b11, PF, PC, 0, 0, 0, 0);
        $display("post reset: hit=%b", bus.btb_hit);
        check_port("post_reset", 0, 1'b0, 32'h0);
        check_port("post_reset", 1, 1'b0, 32'h0);
        drive(0, 2'b11, PA, 32'h1000, 0, 0, 0, 0);
        $display("post reset dropped resolve: hit=%b", bus.btb_hit);
        check_port("dropped_resolve", 0, 1'b0, 32'h0);
        check_port("dropped_resolve", 1, 1'b0, 32'h0);

        // Random traffic over three sets and six tags, with occasional aliases and resets.
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0);
        model_reset();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(99) == 0);
            lv  = 2'($urandom_range(3));
            for (int p = 0; p < NP; p++) begin
                pcs[p] = (32'($urandom_range(9) == 0) << 20) | (32'($urandom_range(5)) << 6) |
                         (32'($urandom_range(2)) << 2) | 32'($urandom_range(3));
            end
            pc0 = pcs[0];
            pc1 = pcs[1];
            rv   = ($urandom_range(9) < 7);
            tk   = ($urandom_range(3) != 0);
            rpc  = (32'($urandom_range(9) == 0) << 20) | (32'($urandom_range(5)) << 6) |
                   (32'($urandom_range(2)) << 2);
            rtgt = $urandom;
            for (int p = 0; p < NP; p++) begin
                e_hit[p] = 1'b0;
                e_tgt[p] = 32'h0;
                if (lv[p]) begin
                    w = model_find(pcs[p]);
                    if (w >= 0) begin
                        e_hit[p] = 1'b1;
                        e_tgt[p] = m_tgt[set_of(pcs[p])][w];
                    end
`ifdef BTB_BYPASS_EN
                    if (rv && pcs[p][15:2] == rpc[15:2]) begin
                        e_hit[p] = tk;
                        e_tgt[p] = tk ? rtgt : 32'h0;
                    end
`endif
                end
                if (rst) begin
                    e_hit[p] = 1'b0;
                    e_tgt[p] = 32'h0;
                end
            end
            drive(rst, lv, pc0, pc1, rv, rpc, rtgt, tk);
            $display("rnd %0d: rst=%0b lv=%b pc=%h,%h rv=%0b tk=%0b rpc=%h hit=%b", n, rst, lv, pc0, pc1,
                     rv, tk, rpc, bus.btb_hit);
            for (int p = 0; p < NP; p++) check_port($sformatf("rnd%0d", n), p, e_hit[p], e_tgt[p]);
            if (rst) model_reset();
            else     model_step(lv, pc0, pc1, rv, rpc, rtgt, tk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
